// File: rtl/ctrl_turnos_xadrez.sv
// Chess-clock turn controller: button sync, turn arbitration, 1 Hz decrement prescaler, flag-fall.
// Optional macro XADREZ_INCREMENTO_EN adds per-move increment pulses on inc1/inc2.
module ctrl_turnos_xadrez #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int MAX_MIN    = 99,
    parameter int INC_SEC    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carga,
    input  logic       j1,
    input  logic       j2,
    input  logic [6:0] chaves,
    input  logic       z1,
    input  logic       z2,
    output logic       load,
    output logic [6:0] carga_val,
    output logic       dec1,
    output logic       dec2,
    output logic [1:0] vez,
    output logic       fim,
    output logic [1:0] vencedor,
    output logic       inc1,
    output logic       inc2
);
    localparam int CW = (CLOCK_FREQ > 2) ? $clog2(CLOCK_FREQ) : 1;

    generate
        if (CLOCK_FREQ < 2 || INC_SEC < 0) begin : g_bad_param
            $error("ctrl_turnos_xadrez: CLOCK_FREQ must be >= 2 and INC_SEC >= 0");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, PRONTO, RUN1, RUN2, FIM} estado_t;

    estado_t         estado_reg, estado_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [1:0]      vencedor_reg, vencedor_next;
    logic [1:0]      vez_reg, vez_next;
    logic [6:0]      carga_val_reg;
    logic            load_reg;
    logic            dec1_reg, dec1_next, dec2_reg, dec2_next;
    logic            tick;
    logic            run_next;
    logic [1:0]      jx, s1_reg, s2_reg, press;

    assign jx = {j2, j1};

    // Two-flop synchroniser per button; a press is the first cycle s1 is high after being low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= jx[gi];
                    s2_reg[gi] <= s1_reg[gi];
                end
            end
            assign press[gi] = s1_reg[gi] & ~s2_reg[gi];
        end
    endgenerate

    assign tick = ((estado_reg == RUN1) || (estado_reg == RUN2)) &&
                  (cnt_reg == CW'(CLOCK_FREQ - 1));

    always_comb begin
        estado_next   = estado_reg;
        vencedor_next = vencedor_reg;
        if (carga) begin
            estado_next   = PRONTO;
            vencedor_next = 2'b00;
        end else begin
            case (estado_reg)
                PRONTO: begin
                    if (press == 2'b01)      estado_next = RUN2;
                    else if (press == 2'b10) estado_next = RUN1;
                end
                RUN1: begin
                    // Flag-fall beats a press arriving in the same cycle.
                    if (z1) begin
                        estado_next   = FIM;
                        vencedor_next = 2'b10;
                    end else if (press[0]) begin
                        estado_next = RUN2;
                    end
                end
                RUN2: begin
                    if (z2) begin
                        estado_next   = FIM;
                        vencedor_next = 2'b01;
                    end else if (press[1]) begin
                        estado_next = RUN1;
                    end
                end
                default: estado_next = estado_reg;
            endcase
        end

        run_next = (estado_next == RUN1) || (estado_next == RUN2);
        if (!run_next || (estado_next != estado_reg)) cnt_next = '0;
        else if (tick)                                 cnt_next = '0;
        else                                           cnt_next = cnt_reg + 1'b1;

        // A decrement only counts for a second the player actually finished on the clock.
        dec1_next = (estado_reg == RUN1) && (estado_next == RUN1) && tick && !z1;
        dec2_next = (estado_reg == RUN2) && (estado_next == RUN2) && tick && !z2;

        case (estado_reg)
            RUN1:    vez_next = 2'b01;
            RUN2:    vez_next = 2'b10;
            default: vez_next = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg    <= IDLE;
            cnt_reg       <= '0;
            vencedor_reg  <= 2'b00;
            vez_reg       <= 2'b00;
            carga_val_reg <= 7'd0;
            load_reg      <= 1'b0;
            dec1_reg      <= 1'b0;
            dec2_reg      <= 1'b0;
        end else begin
            estado_reg   <= estado_next;
            cnt_reg      <= cnt_next;
            vencedor_reg <= vencedor_next;
            vez_reg      <= vez_next;
            load_reg     <= carga;
            dec1_reg     <= dec1_next;
            dec2_reg     <= dec2_next;
            if (carga)
                carga_val_reg <= (chaves > 7'(MAX_MIN)) ? 7'(MAX_MIN) : chaves;
        end
    end

`ifdef XADREZ_INCREMENTO_EN
    logic inc1_reg, inc2_reg;

    // Only a turn-ending press reaches RUN2 from RUN1 (and vice versa), so no start or FIM increments.
    always_ff @(posedge clock) begin
        if (reset) begin
            inc1_reg <= 1'b0;
            inc2_reg <= 1'b0;
        end else begin
            inc1_reg <= (estado_reg == RUN1) && (estado_next == RUN2);
            inc2_reg <= (estado_reg == RUN2) && (estado_next == RUN1);
        end
    end

    assign inc1 = inc1_reg;
    assign inc2 = inc2_reg;
`else
    assign inc1 = 1'b0;
    assign inc2 = 1'b0;
`endif

    assign load      = load_reg;
    assign carga_val = carga_val_reg;
    assign dec1      = dec1_reg;
    assign dec2      = dec2_reg;
    assign vez       = vez_reg;
    assign fim       = (estado_reg == FIM);
    assign vencedor  = vencedor_reg;
endmodule

// File: tb/tb_ctrl_turnos_xadrez.sv
// Scoreboard bench for ctrl_turnos_xadrez: a game-level model predicts outputs each edge, a monitor compares.
module tb_ctrl_turnos_xadrez;
    localparam int CF = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       carga = 1'b0;
    logic       j1 = 1'b0, j2 = 1'b0;
    logic [6:0] chaves = 7'd0;
    logic       z1 = 1'b0, z2 = 1'b0;
    logic       load, dec1, dec2, fim, inc1, inc2;
    logic [6:0] carga_val;
    logic [1:0] vez, vencedor;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    bit done = 1'b0;

    ctrl_turnos_xadrez #(.CLOCK_FREQ(CF), .MAX_MIN(99), .INC_SEC(5)) dut (
        .clock(clock), .reset(reset), .carga(carga), .j1(j1), .j2(j2), .chaves(chaves),
        .z1(z1), .z2(z2), .load(load), .carga_val(carga_val), .dec1(dec1), .dec2(dec2),
        .vez(vez), .fim(fim), .vencedor(vencedor), .inc1(inc1), .inc2(inc2)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       load;
        logic [6:0] cv;
        logic       dec1;
        logic       dec2;
        logic [1:0] vez;
        logic       fim;
        logic [1:0] ven;
        logic       inc1;
        logic       inc2;
    } exp_t;

    exp_t exp_q[$];

`ifdef XADREZ_INCREMENTO_EN
    localparam bit INC_ON = 1'b1;
`else
    localparam bit INC_ON = 1'b0;
`endif

    // Game model: phase 0 idle, 1 ready, 2 player1 running, 3 player2 running, 4 over.
    // A press happens on the edge where the button has already been seen high exactly once.
    int         ph = 0, win = 0, elapsed = 0, hold1 = 0, hold2 = 0;
    logic [6:0] cv = 7'd0;

    initial begin : model
        exp_t e;
        int   nph;
        bit   p1, p2, stay;
        forever begin
            @(posedge clock);
            #1;
            e = '0;
            if (reset) begin
                ph = 0; win = 0; elapsed = 0; hold1 = 0; hold2 = 0; cv = 7'd0;
            end else begin
                p1 = (hold1 == 1);
                p2 = (hold2 == 1);
                hold1 = j1 ? ((hold1 < 2) ? hold1 + 1 : 2) : 0;
                hold2 = j2 ? ((hold2 < 2) ? hold2 + 1 : 2) : 0;
                e.vez = (ph == 2) ? 2'b01 : (ph == 3) ? 2'b10 : 2'b00;
                nph = ph;
                if (carga) begin
                    nph = 1; win = 0;
                end else if (ph == 1) begin
                    if (p1 && !p2) nph = 3;
                    else if (p2 && !p1) nph = 2;
                end else if (ph == 2) begin
                    if (z1) begin nph = 4; win = 2; end
                    else if (p1) nph = 3;
                end else if (ph == 3) begin
                    if (z2) begin nph = 4; win = 1; end
                    else if (p2) nph = 2;
                end
                stay = (nph == ph) && (ph == 2 || ph == 3);
                e.dec1 = stay && ph == 2 && (elapsed % CF == CF - 1) && !z1;
                e.dec2 = stay && ph == 3 && (elapsed % CF == CF - 1) && !z2;
                elapsed = stay ? elapsed + 1 : 0;
                e.inc1 = INC_ON && ph == 2 && nph == 3;
                e.inc2 = INC_ON && ph == 3 && nph == 2;
                e.load = carga;
                if (carga) cv = (chaves > 7'd99) ? 7'd99 : chaves;
                ph = nph;
            end
            e.cv  = cv;
            e.fim = (ph == 4);
            e.ven = win[1:0];
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e, got;
        forever begin
            @(posedge clock);
            #3;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{load, carga_val, dec1, dec2, vez, fim, vencedor, inc1, inc2};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got load=%b cv=%0d dec=%b%b vez=%b fim=%b ven=%b inc=%b%b need load=%b cv=%0d dec=%b%b vez=%b fim=%b ven=%b inc=%b%b",
                             cycle, got.load, got.cv, got.dec1, got.dec2, got.vez, got.fim, got.ven, got.inc1, got.inc2,
                             e.load, e.cv, e.dec1, e.dec2, e.vez, e.fim, e.ven, e.inc1, e.inc2);
                end else if (e.dec1 || e.dec2 || e.inc1 || e.inc2) begin
                    $display("txn cycle=%0d dec=%b%b inc=%b%b vez=%b", cycle, e.dec1, e.dec2, e.inc1, e.inc2, e.vez);
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin : stimulus
        hold(7);
        reset = 1'b0;
        // load 5 minutes
        carga = 1'b1; chaves = 7'd5; hold(1);
        carga = 1'b0; hold(3);
        // player 2 starts the game, player 1 runs
        j2 = 1'b1; hold(10); j2 = 1'b0; hold(13);
        // player 1 ends the turn
        j1 = 1'b1; hold(3); j1 = 1'b0; hold(9);
        // flag-fall with a simultaneous press
        z2 = 1'b1; j2 = 1'b1; hold(2); z2 = 1'b0; j2 = 1'b0; hold(2);
        j1 = 1'b1; hold(3); j1 = 1'b0; hold(3);
        // reload from game over with saturation
        carga = 1'b1; chaves = 7'd120; hold(1); carga = 1'b0; hold(2);
        j2 = 1'b1; hold(3); j2 = 1'b0; hold(6);
        // reset mid-second, then presses must be ignored
        reset = 1'b1; hold(1); reset = 1'b0;
        j1 = 1'b1; hold(3); j1 = 1'b0; j2 = 1'b1; hold(3); j2 = 1'b0; hold(3);
        // zero minutes: first running state flags at once
        carga = 1'b1; chaves = 7'd0; hold(1); carga = 1'b0; hold(1);
        j1 = 1'b1; hold(3); j1 = 1'b0; z2 = 1'b1; hold(4); z2 = 1'b0; hold(2);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            carga = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0:       chaves = 7'd0;
                1:       chaves = 7'($urandom_range(100, 127));
                default: chaves = 7'($urandom_range(1, 99));
            endcase
            if ($urandom_range(0, 5) == 0) j1 = ~j1;
            if ($urandom_range(0, 5) == 0) j2 = ~j2;
            z1 = ($urandom_range(0, 59) == 0);
            z2 = ($urandom_range(0, 59) == 0);
            hold(1);
        end
        reset = 1'b0; carga = 1'b0; j1 = 1'b0; j2 = 1'b0; z1 = 1'b0; z2 = 1'b0;
        hold(4);
        done = 1'b1;
    end

    initial begin : finisher
        wait (done);
        @(posedge clock);
        #4;
        checks++;
        if (exp_q.size() > 1) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d need<=1", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time_limit reached");
        $fatal(1, "timeout");
    end
endmodule
